// File: rtl/aes_iter_core.sv
// Iterative AES core (128/192/256-bit keys), one round per clock, with an
// on-chip key expansion engine and round-key store. Byte 0 sits at the MSBs.

// GF(2^8) multiplicative inverse (0 maps to 0), computed as a^254.
module aes_gf_inv (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (z[i] ? t : 8'h00);
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127;
  assign x2   = gmul(a, a);
  assign x3   = gmul(x2, a);
  assign x6   = gmul(x3, x3);
  assign x7   = gmul(x6, a);
  assign x14  = gmul(x7, x7);
  assign x15  = gmul(x14, a);
  assign x30  = gmul(x15, x15);
  assign x31  = gmul(x30, a);
  assign x62  = gmul(x31, x31);
  assign x63  = gmul(x62, a);
  assign x126 = gmul(x63, x63);
  assign x127 = gmul(x126, a);
  assign y    = gmul(x127, x127);
endmodule

// Forward S-box: inverse followed by the AES affine transform.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] b;
  aes_gf_inv u_inv (.a(a), .y(b));
  assign y = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
endmodule

// Inverse S-box: inverse affine transform followed by the field inverse.
module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] t;
  assign t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
  aes_gf_inv u_inv (.a(t), .y(y));
endmodule

module aes_iter_core #(
  parameter int NK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_load,
  input  logic [32*NK-1:0] key,
  output logic             key_ready,
  input  logic             start,
  input  logic             mode,
  input  logic [127:0]     din,
  output logic             busy,
  output logic             done,
  output logic [127:0]     dout
);
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam int IW = $clog2(NW);
  localparam int KW = $clog2(NK);
  localparam int RW = 4;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // inv=1 selects InvShiftRows; byte k of the block is row k%4, column k/4
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (inv) o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
        else     o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  // InvMixColumns is a cheap pre-multiply followed by the forward MixColumns
  function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3, u, v;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      u  = inv ? xtime(xtime(a0 ^ a2)) : 8'h00;
      v  = inv ? xtime(xtime(a1 ^ a3)) : 8'h00;
      a0 = a0 ^ u;
      a1 = a1 ^ v;
      a2 = a2 ^ u;
      a3 = a3 ^ v;
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  typedef enum logic [1:0] {K_IDLE, K_EXPAND, K_READY} kstate_t;
  typedef enum logic {C_IDLE, C_RUN} cstate_t;

  kstate_t         kstate_r, kstate_s;
  cstate_t         cstate_r, cstate_s;
  logic [31:0]     w_r [NW];
  logic [IW-1:0]   ki_r;
  logic [KW-1:0]   kmod_r;
  logic [7:0]      rcon_r;
  logic [31:0]     prev_s, old_s, sub_in_s, ksub_s, f_s, new_word_s;
  logic            load_ok_s, last_word_s, accept_s, last_round_s, sel_mode_s;
  logic [RW-1:0]   r_r, sel_r_s;
  logic            mode_r;
  logic [127:0]    state_r, sb_s, isr_s, isb_s, enc_s, dec_s, round_s, rk_s;
  logic [IW-1:0]   rk_base_s;

  // ---------------- key expansion ----------------
  assign load_ok_s   = key_load && (cstate_r == C_IDLE);
  assign last_word_s = (ki_r == IW'(NW - 1));
  assign prev_s      = w_r[ki_r - IW'(1)];
  assign old_s       = w_r[ki_r - IW'(NK)];
  assign sub_in_s    = (kmod_r == KW'(0)) ? {prev_s[23:0], prev_s[31:24]} : prev_s;

  for (genvar g = 0; g < 4; g++) begin : g_ksbox
    aes_sbox u_ksb (.a(sub_in_s[31-8*g -: 8]), .y(ksub_s[31-8*g -: 8]));
  end

  // Key schedule core function f(w[i-1]) and the new word
  always_comb begin
    f_s = prev_s;
    if (kmod_r == KW'(0))                      f_s = ksub_s ^ {rcon_r, 24'h000000};
    else if ((NK == 8) && (int'(kmod_r) == 4)) f_s = ksub_s;
    else                                       f_s = prev_s;
    new_word_s = old_s ^ f_s;
  end

  // Key FSM next state; a fresh key_load always restarts expansion
  always_comb begin
    kstate_s = kstate_r;
    if (load_ok_s) begin
      kstate_s = K_EXPAND;
    end else begin
      case (kstate_r)
        K_IDLE:   kstate_s = K_IDLE;
        K_EXPAND: kstate_s = last_word_s ? K_READY : K_EXPAND;
        K_READY:  kstate_s = K_READY;
        default:  kstate_s = K_IDLE;
      endcase
    end
  end

  // Key FSM state, word index, NK-phase counter, Rcon and key_ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kstate_r  <= K_IDLE;
      ki_r      <= IW'(0);
      kmod_r    <= KW'(0);
      rcon_r    <= 8'h01;
      key_ready <= 1'b0;
    end else begin
      kstate_r  <= kstate_s;
      key_ready <= (kstate_s == K_READY);
      if (load_ok_s) begin
        ki_r   <= IW'(NK);
        kmod_r <= KW'(0);
        rcon_r <= 8'h01;
      end else if (kstate_r == K_EXPAND) begin
        ki_r   <= ki_r + IW'(1);
        kmod_r <= (kmod_r == KW'(NK - 1)) ? KW'(0) : kmod_r + KW'(1);
        rcon_r <= (kmod_r == KW'(0)) ? xtime(rcon_r) : rcon_r;
      end
    end
  end

  // Round-key store: contents are don't-care until expansion completes
  always_ff @(posedge clk) begin
    if (load_ok_s) begin
      for (int j = 0; j < NK; j++) w_r[j] <= key[32*(NK-j)-1 -: 32];
    end else if (kstate_r == K_EXPAND) begin
      w_r[ki_r] <= new_word_s;
    end
  end

  // ---------------- cipher datapath ----------------
  assign accept_s     = start && key_ready && (cstate_r == C_IDLE) && !key_load;
  assign last_round_s = (cstate_r == C_RUN) && (r_r == RW'(NR));
  assign isr_s        = shift_rows(state_r, 1'b1);

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    aes_sbox     u_sb  (.a(state_r[127-8*g -: 8]), .y(sb_s[127-8*g -: 8]));
    aes_inv_sbox u_isb (.a(isr_s[127-8*g -: 8]),   .y(isb_s[127-8*g -: 8]));
  end

  // Round-key select: round 0 on acceptance, otherwise the current round
  always_comb begin
    sel_mode_s = accept_s ? mode : mode_r;
    sel_r_s    = accept_s ? RW'(0) : r_r;
    if (sel_mode_s) rk_base_s = IW'(4 * (NR - int'(sel_r_s)));
    else            rk_base_s = IW'(4 * int'(sel_r_s));
    rk_s = {w_r[rk_base_s], w_r[rk_base_s + IW'(1)],
            w_r[rk_base_s + IW'(2)], w_r[rk_base_s + IW'(3)]};
  end

  // One encrypt or decrypt round; the final round skips (Inv)MixColumns
  always_comb begin
    enc_s = shift_rows(sb_s, 1'b0);
    dec_s = isb_s ^ rk_s;
    if (r_r != RW'(NR)) begin
      enc_s = mix_cols(enc_s, 1'b0) ^ rk_s;
      dec_s = mix_cols(dec_s, 1'b1);
    end else begin
      enc_s = enc_s ^ rk_s;
      dec_s = dec_s;
    end
    round_s = mode_r ? dec_s : enc_s;
  end

  // Cipher FSM next state
  always_comb begin
    cstate_s = cstate_r;
    case (cstate_r)
      C_IDLE:  cstate_s = accept_s ? C_RUN : C_IDLE;
      C_RUN:   cstate_s = (r_r == RW'(NR)) ? C_IDLE : C_RUN;
      default: cstate_s = C_IDLE;
    endcase
  end

  // Cipher state register, round counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cstate_r <= C_IDLE;
      state_r  <= 128'h0;
      r_r      <= RW'(0);
      mode_r   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dout     <= 128'h0;
    end else begin
      cstate_r <= cstate_s;
      busy     <= (cstate_s == C_RUN);
      done     <= last_round_s;
      if (accept_s) begin
        state_r <= din ^ rk_s;
        mode_r  <= mode;
        r_r     <= RW'(1);
      end else if (cstate_r == C_RUN) begin
        state_r <= round_s;
        r_r     <= r_r + RW'(1);
        if (last_round_s) dout <= round_s;
      end
    end
  end
endmodule

// File: tb/tb_aes_iter_core.sv
// Directed bench for aes_iter_core: FIPS-197 vectors on NK=4/6/8 instances,
// protocol corner cases and asynchronous reset.
module tb_aes_iter_core;
  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] key_s;
  logic         mode;
  logic [127:0] din;
  logic         kl [3];
  logic         st [3];
  logic         kr [3];
  logic         bz [3];
  logic         dn [3];
  logic [127:0] dq [3];
  int           checks = 0;
  int           failures = 0;
  int           dcnt [3] = '{0, 0, 0};

  localparam logic [127:0] PT_A  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_A  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_B4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_B6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_B8 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] K_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_B4  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K_B6  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K_B8  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  always #5 clk = ~clk;

  aes_iter_core #(.NK(4)) u_nk4 (.clk(clk), .reset(reset), .key_load(kl[0]), .key(key_s[255:128]),
    .key_ready(kr[0]), .start(st[0]), .mode(mode), .din(din), .busy(bz[0]), .done(dn[0]), .dout(dq[0]));
  aes_iter_core #(.NK(6)) u_nk6 (.clk(clk), .reset(reset), .key_load(kl[1]), .key(key_s[255:64]),
    .key_ready(kr[1]), .start(st[1]), .mode(mode), .din(din), .busy(bz[1]), .done(dn[1]), .dout(dq[1]));
  aes_iter_core #(.NK(8)) u_nk8 (.clk(clk), .reset(reset), .key_load(kl[2]), .key(key_s),
    .key_ready(kr[2]), .start(st[2]), .mode(mode), .din(din), .busy(bz[2]), .done(dn[2]), .dout(dq[2]));

  // Count done pulses per instance
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) dcnt[i] <= dcnt[i] + (dn[i] ? 1 : 0);
  end

  task automatic check_value(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load_key(input int idx, input int exp_lat, input string tag);
    int n;
    kl[idx] = 1'b1;
    @(posedge clk); #1;
    kl[idx] = 1'b0;
    n = 0;
    while (!kr[idx] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_value(tag, 256'(n), 256'(exp_lat));
  endtask

  task automatic pulse_start(input int idx, input logic md, input logic [127:0] data);
    mode    = md;
    din     = data;
    st[idx] = 1'b1;
    @(posedge clk); #1;
    st[idx] = 1'b0;
  endtask

  // n counts cycles from the start cycle through the done cycle
  task automatic wait_done(input int idx, output int n);
    n = 1;
    while (!dn[idx] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    int n;
    int d0;
    reset = 1'b1;
    key_s = 256'h0;
    mode  = 1'b0;
    din   = 128'h0;
    for (int i = 0; i < 3; i++) begin
      kl[i] = 1'b0;
      st[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_value("rst_key_ready", 256'(kr[0]), 256'd0);
    check_value("rst_busy", 256'(bz[0]), 256'd0);
    check_value("rst_done", 256'(dn[0]), 256'd0);
    check_value("rst_dout", 256'(dq[0]), 256'd0);

    // start before any key is ready is dropped
    d0 = dcnt[0];
    pulse_start(0, 1'b0, PT_A);
    repeat (15) @(posedge clk);
    #1;
    check_value("early_start_done", 256'(dcnt[0] - d0), 256'd0);
    check_value("early_start_dout", 256'(dq[0]), 256'd0);

    // NK=4 encrypt, FIPS-197 appendix B
    key_s = {K_A, 128'h0};
    load_key(0, 40, "nk4_key_lat");
    pulse_start(0, 1'b0, PT_A);
    wait_done(0, n);
    check_value("nk4_enc_lat", 256'(n), 256'd11);
    check_value("nk4_enc_dout", 256'(dq[0]), 256'(CT_A));
    check_value("nk4_busy_in_done", 256'(bz[0]), 256'd0);
    @(posedge clk); #1;
    check_value("nk4_done_width", 256'(dn[0]), 256'd0);

    // start while busy and key_load while busy are both ignored
    d0 = dcnt[0];
    pulse_start(0, 1'b0, PT_A);
    repeat (2) @(posedge clk);
    #1;
    pulse_start(0, 1'b1, 128'hdeadbeefdeadbeefdeadbeefdeadbeef);
    key_s = {K_B4, 128'h0};
    kl[0] = 1'b1;
    @(posedge clk); #1;
    kl[0] = 1'b0;
    wait_done(0, n);
    check_value("busy_ops_dout", 256'(dq[0]), 256'(CT_A));
    check_value("load_busy_keyrdy", 256'(kr[0]), 256'd1);
    repeat (20) @(posedge clk);
    #1;
    check_value("busy_ops_done_cnt", 256'(dcnt[0] - d0), 256'd1);
    check_value("busy_ops_dout_hold", 256'(dq[0]), 256'(CT_A));

    // start together with key_load: key_load wins, start dropped
    d0 = dcnt[0];
    mode  = 1'b1;
    din   = CT_B4;
    kl[0] = 1'b1;
    st[0] = 1'b1;
    @(posedge clk); #1;
    kl[0] = 1'b0;
    st[0] = 1'b0;
    check_value("both_key_ready", 256'(kr[0]), 256'd0);
    check_value("both_busy", 256'(bz[0]), 256'd0);
    n = 0;
    while (!kr[0] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_value("both_key_lat", 256'(n), 256'd40);
    check_value("both_done_cnt", 256'(dcnt[0] - d0), 256'd0);
    check_value("both_dout_hold", 256'(dq[0]), 256'(CT_A));

    // NK=4 decrypt, FIPS-197 appendix C.1
    pulse_start(0, 1'b1, CT_B4);
    wait_done(0, n);
    check_value("nk4_dec_lat", 256'(n), 256'd11);
    check_value("nk4_dec_dout", 256'(dq[0]), 256'(PT_B));

    // NK=6 decrypt, FIPS-197 appendix C.2
    key_s = {K_B6, 64'h0};
    load_key(1, 46, "nk6_key_lat");
    pulse_start(1, 1'b1, CT_B6);
    wait_done(1, n);
    check_value("nk6_dec_lat", 256'(n), 256'd13);
    check_value("nk6_dec_dout", 256'(dq[1]), 256'(PT_B));

    // NK=8 encrypt then decrypt back-to-back, second start in the done cycle
    key_s = K_B8;
    load_key(2, 52, "nk8_key_lat");
    pulse_start(2, 1'b0, PT_B);
    wait_done(2, n);
    check_value("nk8_enc_lat", 256'(n), 256'd15);
    check_value("nk8_enc_dout", 256'(dq[2]), 256'(CT_B8));
    pulse_start(2, 1'b1, CT_B8);
    wait_done(2, n);
    check_value("nk8_b2b_spacing", 256'(n), 256'd15);
    check_value("nk8_dec_dout", 256'(dq[2]), 256'(PT_B));

    // reset mid-round (NK=4) and mid-expansion (NK=6)
    d0 = dcnt[0];
    pulse_start(0, 1'b0, PT_B);
    kl[1] = 1'b1;
    @(posedge clk); #1;
    kl[1] = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_value("arst_busy", 256'(bz[0]), 256'd0);
    check_value("arst_done", 256'(dn[0]), 256'd0);
    check_value("arst_key_ready", 256'(kr[0]), 256'd0);
    check_value("arst_dout", 256'(dq[0]), 256'd0);
    check_value("arst_nk8_dout", 256'(dq[2]), 256'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check_value("post_rst_nk6_key_ready", 256'(kr[1]), 256'd0);
    check_value("post_rst_nk4_key_ready", 256'(kr[0]), 256'd0);
    check_value("post_rst_no_done", 256'(dcnt[0] - d0), 256'd0);

    key_s = {K_A, 128'h0};
    load_key(0, 40, "rerun_key_lat");
    pulse_start(0, 1'b0, PT_A);
    wait_done(0, n);
    check_value("rerun_lat", 256'(n), 256'd11);
    check_value("rerun_dout", 256'(dq[0]), 256'(CT_A));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
